outport: RTL and testbench

OUTPORT -- requirements
Module: outport

---
 rtl/outport_pkg.sv | 46 ++++
 rtl/outport_if.sv | 29 ++
 rtl/outport_sync_fifo.sv | 82 ++++++++
 rtl/outport.sv | 100 ++++++++++
 tb/tb_outport.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/outport_pkg.sv
// Shared constants and the sample conversion helper for the output port.
package outport_pkg;

   // Width of the saturating event counters.
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

   // Working width of the conversion; wide enough that rounding never overflows.
   localparam int CONV_W = 64;

   typedef struct packed {
      logic [CONV_W-1:0] word;
      logic              clip;
   } conv_t;

   // Round-half-up arithmetic shift followed by clipping to an (out_msb+1)-bit range.
   function automatic conv_t sat_round(input logic signed [CONV_W-1:0] x,
                                       input int shift,
                                       input int out_msb);
      logic signed [CONV_W-1:0] sum;
      logic signed [CONV_W-1:0] shifted;
      logic signed [CONV_W-1:0] hi;
      logic signed [CONV_W-1:0] lo;
      conv_t                    res;
      if (shift > 0) begin
         sum = x + (64'sd1 <<< (shift - 1));
      end else begin
         sum = x;
      end
      shifted = sum >>> shift;
      hi      = (64'sd1 <<< out_msb) - 64'sd1;
      lo      = -(64'sd1 <<< out_msb);
      if (shifted > hi) begin
         res.word = hi;
         res.clip = 1'b1;
      end else if (shifted < lo) begin
         res.word = lo;
         res.clip = 1'b1;
      end else begin
         res.word = shifted;
         res.clip = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/outport_if.sv
// Sample input and ready/valid output stream of the output port.
interface outport_if #(
   parameter int MSB     = 31,
   parameter int OUT_MSB = 23
);
   logic [MSB:0]     internal_data;
   logic             internal_data_en;
   logic [OUT_MSB:0] out_data;
   logic             out_valid;
   logic             out_ready;

   // The port itself: takes samples, produces the output stream.
   modport master (
      input  internal_data,
      input  internal_data_en,
      input  out_ready,
      output out_data,
      output out_valid
   );

   // The surroundings: supplies samples, consumes the output stream.
   modport slave (
      output internal_data,
      output internal_data_en,
      output out_ready,
      input  out_data,
      input  out_valid
   );
endinterface

// File: rtl/outport_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word.
// The head register holds its last value once the FIFO runs empty.
module sync_fifo #(
   parameter int   WIDTH = 24,
   parameter int   DEPTH = 4,
   localparam int  AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW-1:0]    rd_next_s;
   logic [AW:0]      count_r;
   logic [WIDTH-1:0] head_r;
   logic             full_s;
   logic             empty_s;
   logic             pop_en_s;
   logic             wr_en_s;

   assign full_s    = (count_r == (AW+1)'(DEPTH));
   assign empty_s   = (count_r == (AW+1)'(0));
   assign pop_en_s  = pop & ~empty_s;
   // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
   assign wr_en_s   = push & (~full_s | pop_en_s);
   assign rd_next_s = rd_ptr_r + AW'(1);

   // Storage array; no reset needed since only counted entries are ever read.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers, occupancy and the show-ahead head register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         head_r   <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_en_s) begin
            rd_ptr_r <= rd_next_s;
         end
         case ({wr_en_s, pop_en_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
         if (pop_en_s) begin
            if (count_r > (AW+1)'(1)) begin
               head_r <= mem_r[rd_next_s];
            end else if (wr_en_s) begin
               head_r <= push_data;
            end else begin
               head_r <= head_r;
            end
         end else if (empty_s && wr_en_s) begin
            head_r <= push_data;
         end else begin
            head_r <= head_r;
         end
      end
   end

   assign head  = head_r;
   assign full  = full_s;
   assign empty = empty_s;
   assign level = count_r;
endmodule

// File: rtl/outport.sv
// Output port: rounds/clips internal samples to the external width,
// buffers them in a FIFO and keeps drop/saturation statistics.
module outport
   import outport_pkg::*;
#(
   parameter int OUT_MSB = 23,
   parameter int MSB     = 31,
   parameter int SHIFT   = 0,
   parameter int DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   outport_if.master              bus,
   input  logic                   clr_flags,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic [CNT_W-1:0]       sat_count,
   output logic [CNT_W-1:0]       drop_count
);
   conv_t            conv_s;
   logic             unused_conv_s;
   logic [OUT_MSB:0] s1_data_r;
   logic             s1_valid_r;
   logic             s1_sat_r;
   logic             full_s;
   logic             empty_s;
   logic             drop_s;
   logic             overflow_r;
   logic [CNT_W-1:0] sat_count_r;
   logic [CNT_W-1:0] drop_count_r;

   assign conv_s = sat_round({{(CONV_W-MSB-1){bus.internal_data[MSB]}}, bus.internal_data},
                             SHIFT, OUT_MSB);
   assign unused_conv_s = ^conv_s.word[CONV_W-1:OUT_MSB+1];

   // Stage 1: capture the converted sample, its valid bit and clip event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_data_r  <= '0;
         s1_valid_r <= 1'b0;
         s1_sat_r   <= 1'b0;
      end else begin
         s1_valid_r <= bus.internal_data_en;
         s1_sat_r   <= bus.internal_data_en & conv_s.clip;
         if (bus.internal_data_en) begin
            s1_data_r <= conv_s.word[OUT_MSB:0];
         end else begin
            s1_data_r <= s1_data_r;
         end
      end
   end

   sync_fifo #(
      .WIDTH (OUT_MSB + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s1_valid_r),
      .push_data (s1_data_r),
      .pop       (bus.out_ready),
      .head      (bus.out_data),
      .full      (full_s),
      .empty     (empty_s),
      .level     (level)
   );

   assign bus.out_valid = ~empty_s;
   // A full FIFO loses the incoming word only when nothing leaves that cycle.
   assign drop_s = s1_valid_r & full_s & ~bus.out_ready;

   // Sticky overflow and saturating counters; a clear wins over same-cycle events.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r   <= 1'b0;
         sat_count_r  <= '0;
         drop_count_r <= '0;
      end else if (clr_flags) begin
         overflow_r   <= 1'b0;
         sat_count_r  <= '0;
         drop_count_r <= '0;
      end else begin
         overflow_r <= overflow_r | drop_s;
         if (s1_sat_r && (sat_count_r != CNT_MAX)) begin
            sat_count_r <= sat_count_r + CNT_W'(1);
         end else begin
            sat_count_r <= sat_count_r;
         end
         if (drop_s && (drop_count_r != CNT_MAX)) begin
            drop_count_r <= drop_count_r + CNT_W'(1);
         end else begin
            drop_count_r <= drop_count_r;
         end
      end
   end

   assign overflow   = overflow_r;
   assign sat_count  = sat_count_r;
   assign drop_count = drop_count_r;
endmodule

// File: tb/tb_outport.sv
// Scoreboard bench for outport: dut0 uses the defaults, dut1 uses SHIFT=4.
module tb_outport;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   outport_if #(.MSB(31), .OUT_MSB(23)) if0 ();
   outport_if #(.MSB(31), .OUT_MSB(23)) if1 ();

   logic        clr0, clr1;
   logic [2:0]  level0, level1;
   logic        ovf0, ovf1;
   logic [15:0] sat0, sat1, drop0, drop1;

   outport #(.OUT_MSB(23), .MSB(31), .SHIFT(0), .DEPTH(4)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.master), .clr_flags(clr0), .level(level0),
      .overflow(ovf0), .sat_count(sat0), .drop_count(drop0));

   outport #(.OUT_MSB(23), .MSB(31), .SHIFT(4), .DEPTH(4)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.master), .clr_flags(clr1), .level(level1),
      .overflow(ovf1), .sat_count(sat1), .drop_count(drop1));

   int n_cmp = 0;
   int n_bad = 0;
   logic [23:0] exp_q0[$];
   logic [23:0] exp_q1[$];
   logic        stall0 = 1'b0;
   logic [23:0] stall_data0 = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [31:0] d, input logic keep, input logic [23:0] e);
      if0.internal_data    = d;
      if0.internal_data_en = 1'b1;
      if (keep) exp_q0.push_back(e);
      tick();
      if0.internal_data_en = 1'b0;
   endtask

   task automatic send1(input logic [31:0] d, input logic [23:0] e);
      if1.internal_data    = d;
      if1.internal_data_en = 1'b1;
      exp_q1.push_back(e);
      tick();
      if1.internal_data_en = 1'b0;
   endtask

   // Monitor: every accepted output word is popped from its scoreboard and compared.
   always @(negedge clk) begin
      if (if0.out_valid && if0.out_ready) begin
         if (exp_q0.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut0 unexpected word: got 0x%0h, expected none", if0.out_data);
         end else begin
            chk("dut0 word", if0.out_data, exp_q0.pop_front());
         end
      end
      if (if1.out_valid && if1.out_ready) begin
         if (exp_q1.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut1 unexpected word: got 0x%0h, expected none", if1.out_data);
         end else begin
            chk("dut1 word", if1.out_data, exp_q1.pop_front());
         end
      end
      if (stall0 && !rst) begin
         chk("dut0 stall valid", if0.out_valid, 1'b1);
         chk("dut0 stall data", if0.out_data, stall_data0);
      end
      stall0      <= if0.out_valid && !if0.out_ready && !rst;
      stall_data0 <= if0.out_data;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      clr0 = 1'b0; clr1 = 1'b0;
      if0.internal_data = '0; if0.internal_data_en = 1'b0; if0.out_ready = 1'b0;
      if1.internal_data = '0; if1.internal_data_en = 1'b0; if1.out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset out_valid", if0.out_valid, 1'b0);
      chk("reset level", level0, 3'd0);
      chk("reset out_data", if0.out_data, 24'h0);
      chk("reset overflow", ovf0, 1'b0);
      chk("reset sat_count", sat0, 16'd0);
      chk("reset drop_count", drop0, 16'd0);
      tick();
      rst = 1'b0;
      repeat (2) tick();

      // Single sample: two-edge latency, valid for exactly one cycle.
      if0.out_ready = 1'b1;
      send0(32'h0000_1234, 1'b1, 24'h001234);
      @(negedge clk); chk("latency valid edge1", if0.out_valid, 1'b0);
      @(negedge clk); chk("latency valid edge2", if0.out_valid, 1'b1);
      chk("latency data", if0.out_data, 24'h001234);
      @(negedge clk); chk("single valid drops", if0.out_valid, 1'b0);
      chk("empty holds data", if0.out_data, 24'h001234);
      tick();

      // Positive and negative clipping.
      send0(32'h0100_0000, 1'b1, 24'h7FFFFF);
      send0(32'hFF00_0000, 1'b1, 24'h800000);
      repeat (4) tick();
      chk("sat_count after clips", sat0, 16'd2);
      chk("overflow after clips", ovf0, 1'b0);

      // Overfill with the consumer stalled, then drain, then clear.
      if0.out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) send0(32'(i), (i <= 4), 24'(i));
      repeat (3) tick();
      @(negedge clk);
      chk("full level", level0, 3'd4);
      chk("drop_count", drop0, 16'd2);
      chk("overflow set", ovf0, 1'b1);
      chk("full head", if0.out_data, 24'd1);
      tick();
      if0.out_ready = 1'b1;
      repeat (6) tick();
      chk("drained level", level0, 3'd0);
      chk("drained scoreboard", exp_q0.size(), 64'd0);
      clr0 = 1'b1;
      tick();
      clr0 = 1'b0;
      @(negedge clk);
      chk("clr overflow", ovf0, 1'b0);
      chk("clr sat_count", sat0, 16'd0);
      chk("clr drop_count", drop0, 16'd0);
      tick();

      // Push into a full FIFO with a simultaneous pop.
      if0.out_ready = 1'b0;
      for (int i = 10; i <= 13; i++) send0(32'(i), 1'b1, 24'(i));
      repeat (3) tick();
      chk("refill level", level0, 3'd4);
      send0(32'd14, 1'b1, 24'd14);
      if0.out_ready = 1'b1;
      tick();
      if0.out_ready = 1'b0;
      @(negedge clk);
      chk("full push+pop level", level0, 3'd4);
      chk("full push+pop drop_count", drop0, 16'd0);
      tick();
      if0.out_ready = 1'b1;
      repeat (7) tick();
      chk("second drain", exp_q0.size(), 64'd0);

      // Asynchronous reset with queued and in-flight words.
      if0.out_ready = 1'b0;
      for (int i = 20; i <= 23; i++) send0(32'(i), 1'b0, 24'd0);
      chk("pre-reset level", level0, 3'd3);
      rst = 1'b1;
      #1;
      chk("async reset valid", if0.out_valid, 1'b0);
      chk("async reset level", level0, 3'd0);
      repeat (2) tick();
      rst = 1'b0;
      if0.out_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("post-reset valid", if0.out_valid, 1'b0);
      chk("post-reset data", if0.out_data, 24'h0);
      tick();
      send0(32'h0000_0055, 1'b1, 24'h000055);
      @(negedge clk); chk("post-reset latency edge1", if0.out_valid, 1'b0);
      @(negedge clk); chk("post-reset latency edge2", if0.out_valid, 1'b1);
      tick();

      // Rounding with SHIFT=4.
      send1(32'd24,        24'h000002);
      send1(32'hFFFF_FFE8, 24'hFFFFFF);
      send1(32'hFFFF_FFF8, 24'h000000);
      send1(32'd23,        24'h000001);
      repeat (4) tick();
      chk("shift sat_count", sat1, 16'd0);
      send1(32'h7FFF_FFFF, 24'h7FFFFF);
      send1(32'h8000_0000, 24'h800000);
      repeat (4) tick();
      chk("shift clip sat_count", sat1, 16'd2);

      repeat (4) tick();
      chk("final scoreboard dut0", exp_q0.size(), 64'd0);
      chk("final scoreboard dut1", exp_q1.size(), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
